// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the RV32 memory-access stage
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TO_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

  // funct3[1:0] selects size; reserved encodings 011/110/111 fall into the word case
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - selects the addressed lane of a read word and extends it
module load_aligner
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr)
      2'b00:   lane_b = rdata[7:0];
      2'b01:   lane_b = rdata[15:8];
      2'b10:   lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'h0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'h0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 memory stage: load/store bus transactions and writeback
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  mem_state_t      state;
  logic [1:0]      lo_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            load_q;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_next;
  logic [31:0]     load_data;
  logic            is_mem;
  logic            mis;
  logic [3:0]      be_n;
  logic [31:0]     wdata_n;

  assign ex_ready = (state == S_IDLE);
  assign is_mem   = ex_is_load | ex_is_store;
  assign mis      = misaligned(ex_funct3, ex_result[1:0]);
  assign to_next  = to_cnt + TO_W'(1);

  // lane enables and replicated write data; loads reuse the same enables
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << ex_result[1:0];
        wdata_n = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << ex_result[1:0];
        wdata_n = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  load_aligner u_align (
    .rdata  (dmem_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lo_q        <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      load_q      <= 1'b0;
      to_cnt      <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_misalign <= 1'b0;
      wb_bus_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            lo_q        <= ex_result[1:0];
            f3_q        <= ex_funct3;
            rd_q        <= ex_rd;
            load_q      <= ex_is_load;
            to_cnt      <= '0;
            wb_rd       <= ex_rd;
            wb_misalign <= 1'b0;
            wb_bus_err  <= 1'b0;
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= (ex_rd != 5'd0);
              wb_data  <= ex_result;
              state    <= S_DONE;
            end else if (mis) begin
              wb_valid    <= 1'b1;
              wb_we       <= 1'b0;
              wb_data     <= '0;
              wb_misalign <= 1'b1;
              state       <= S_DONE;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= ex_is_store;
              dmem_addr  <= {ex_result[31:2], 2'b00};
              dmem_be    <= be_n;
              dmem_wdata <= wdata_n;
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= load_q && (rd_q != 5'd0);
            wb_data  <= load_q ? load_data : 32'h0;
            state    <= S_DONE;
          end else if (to_next == TO_LIMIT) begin
            dmem_req   <= 1'b0;
            wb_valid   <= 1'b1;
            wb_we      <= 1'b0;
            wb_data    <= '0;
            wb_bus_err <= 1'b1;
            state      <= S_DONE;
          end else begin
            to_cnt <= to_next;
          end
        end
        S_DONE: begin
          wb_valid <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_misalign;
  logic        wb_bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_funct3(ex_funct3),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
  );

  typedef struct {
    logic        rdy0;
    int          req_cnt;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          wb_cyc;
    int          wb_abs;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mis;
    logic        berr;
    logic        rdy_after;
    logic        wbv_after;
    logic        req_after;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation at cycle 0 and records what the DUT does until it retires.
  task automatic run_op(input logic [31:0] res, input logic [31:0] sd, input logic [2:0] f3,
                        input logic ld, input logic st, input logic [4:0] rd, input int ack_at,
                        input logic [31:0] rdata, input logic late_ack, output obs_t o);
    o.rdy0 = 0; o.req_cnt = 0; o.addr = '0; o.be = '0; o.wdata = '0; o.we = 0;
    o.wb_cyc = -1; o.wb_abs = -1; o.wb_we = 0; o.wb_rd = '0; o.wb_data = '0;
    o.mis = 0; o.berr = 0; o.rdy_after = 0; o.wbv_after = 1; o.req_after = 1;
    ex_result = res; ex_store_data = sd; ex_funct3 = f3;
    ex_is_load = ld; ex_is_store = st; ex_rd = rd; ex_valid = 1'b1;
    o.rdy0 = ex_ready;
    for (int c = 1; c <= 20; c++) begin
      step();
      ex_valid = 1'b0;
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (o.req_cnt == 0) begin
          o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
        end
        o.req_cnt++;
      end
      if (wb_valid) begin
        o.wb_cyc = c; o.wb_abs = cyc_cnt; o.wb_we = wb_we; o.wb_rd = wb_rd;
        o.wb_data = wb_data; o.mis = wb_misalign; o.berr = wb_bus_err;
        dmem_ack = late_ack;
        step();
        dmem_ack = 1'b0;
        o.rdy_after = ex_ready; o.wbv_after = wb_valid; o.req_after = dmem_req;
        break;
      end
      if (c == ack_at) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ex_ready got %b want 1", ex_ready); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_dmem_req got %b want 0", dmem_req); end
    n_cmp++; if (dmem_be !== 4'h0) begin n_bad++; $display("FAIL rst_dmem_be got %h want 0", dmem_be); end
    n_cmp++; if (dmem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_dmem_addr got %h want 0", dmem_addr); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
    n_cmp++; if (wb_data !== 32'h0) begin n_bad++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    obs_t o;
    run_op(32'h1234_5678, 32'h0, 3'b000, 1'b0, 1'b0, 5'd5, 0, 32'h0, 1'b0, o);
    n_cmp++; if (o.rdy0 !== 1'b1) begin n_bad++; $display("FAIL pt_ready got %b want 1", o.rdy0); end
    n_cmp++; if (o.req_cnt !== 0) begin n_bad++; $display("FAIL pt_req_cnt got %0d want 0", o.req_cnt); end
    n_cmp++; if (o.wb_cyc !== 1) begin n_bad++; $display("FAIL pt_wb_cycle got %0d want 1", o.wb_cyc); end
    n_cmp++; if (o.wb_we !== 1'b1) begin n_bad++; $display("FAIL pt_wb_we got %b want 1", o.wb_we); end
    n_cmp++; if (o.wb_data !== 32'h1234_5678) begin n_bad++; $display("FAIL pt_wb_data got %h want 12345678", o.wb_data); end
    n_cmp++; if (o.wb_rd !== 5'd5) begin n_bad++; $display("FAIL pt_wb_rd got %0d want 5", o.wb_rd); end
    n_cmp++; if (o.rdy_after !== 1'b1) begin n_bad++; $display("FAIL pt_ready_after got %b want 1", o.rdy_after); end
    run_op(32'h0000_0042, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 0, 32'h0, 1'b0, o);
    n_cmp++; if (o.wb_we !== 1'b0) begin n_bad++; $display("FAIL pt_rd0_we got %b want 0", o.wb_we); end
  endtask

  task automatic test_store();
    obs_t o;
    run_op(32'h0000_0103, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 5'd3, 3, 32'h0, 1'b0, o);
    n_cmp++; if (o.req_cnt !== 3) begin n_bad++; $display("FAIL sb_req_cycles got %0d want 3", o.req_cnt); end
    n_cmp++; if (o.addr !== 32'h0000_0100) begin n_bad++; $display("FAIL sb_addr got %h want 00000100", o.addr); end
    n_cmp++; if (o.be !== 4'b1000) begin n_bad++; $display("FAIL sb_be got %b want 1000", o.be); end
    n_cmp++; if (o.wdata !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_wdata got %h want abababab", o.wdata); end
    n_cmp++; if (o.we !== 1'b1) begin n_bad++; $display("FAIL sb_we got %b want 1", o.we); end
    n_cmp++; if (o.wb_cyc !== 4) begin n_bad++; $display("FAIL sb_wb_cycle got %0d want 4", o.wb_cyc); end
    n_cmp++; if (o.wb_we !== 1'b0) begin n_bad++; $display("FAIL sb_wb_we got %b want 0", o.wb_we); end
    n_cmp++; if (o.req_after !== 1'b0) begin n_bad++; $display("FAIL sb_req_after got %b want 0", o.req_after); end
    run_op(32'h0000_0102, 32'h1234_BEEF, 3'b001, 1'b0, 1'b1, 5'd3, 1, 32'h0, 1'b0, o);
    n_cmp++; if (o.be !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b want 1100", o.be); end
    n_cmp++; if (o.wdata !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL sh_wdata got %h want beefbeef", o.wdata); end
    n_cmp++; if (o.wb_cyc !== 2) begin n_bad++; $display("FAIL sh_wb_cycle got %0d want 2", o.wb_cyc); end
    run_op(32'h0000_0204, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 5'd3, 1, 32'h0, 1'b0, o);
    n_cmp++; if (o.be !== 4'b1111) begin n_bad++; $display("FAIL sw_be got %b want 1111", o.be); end
    n_cmp++; if (o.wdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL sw_wdata got %h want cafef00d", o.wdata); end
    n_cmp++; if (o.addr !== 32'h0000_0204) begin n_bad++; $display("FAIL sw_addr got %h want 00000204", o.addr); end
  endtask

  task automatic test_loads();
    obs_t o;
    run_op(32'h0000_0102, 32'h0, 3'b000, 1'b1, 1'b0, 5'd7, 1, 32'h0080_0000, 1'b0, o);
    n_cmp++; if (o.wb_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data got %h want ffffff80", o.wb_data); end
    n_cmp++; if (o.be !== 4'b0100) begin n_bad++; $display("FAIL lb_be got %b want 0100", o.be); end
    n_cmp++; if (o.we !== 1'b0) begin n_bad++; $display("FAIL lb_dmem_we got %b want 0", o.we); end
    n_cmp++; if (o.wb_we !== 1'b1) begin n_bad++; $display("FAIL lb_wb_we got %b want 1", o.wb_we); end
    n_cmp++; if (o.wb_rd !== 5'd7) begin n_bad++; $display("FAIL lb_wb_rd got %0d want 7", o.wb_rd); end
    n_cmp++; if (o.wb_cyc !== 2) begin n_bad++; $display("FAIL lb_wb_cycle got %0d want 2", o.wb_cyc); end
    run_op(32'h0000_0102, 32'h0, 3'b100, 1'b1, 1'b0, 5'd7, 1, 32'h0080_0000, 1'b0, o);
    n_cmp++; if (o.wb_data !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_data got %h want 00000080", o.wb_data); end
    run_op(32'h0000_0102, 32'h0, 3'b001, 1'b1, 1'b0, 5'd8, 1, 32'h8001_0000, 1'b0, o);
    n_cmp++; if (o.wb_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_data got %h want ffff8001", o.wb_data); end
    n_cmp++; if (o.be !== 4'b1100) begin n_bad++; $display("FAIL lh_be got %b want 1100", o.be); end
    run_op(32'h0000_0102, 32'h0, 3'b101, 1'b1, 1'b0, 5'd8, 1, 32'h8001_0000, 1'b0, o);
    n_cmp++; if (o.wb_data !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_data got %h want 00008001", o.wb_data); end
    run_op(32'h0000_0101, 32'h0, 3'b000, 1'b1, 1'b0, 5'd9, 1, 32'h0000_7F00, 1'b0, o);
    n_cmp++; if (o.wb_data !== 32'h0000_007F) begin n_bad++; $display("FAIL lb_pos_data got %h want 0000007f", o.wb_data); end
    run_op(32'h0000_0100, 32'h0, 3'b010, 1'b1, 1'b0, 5'd10, 2, 32'hDEAD_BEEF, 1'b0, o);
    n_cmp++; if (o.wb_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", o.wb_data); end
    n_cmp++; if (o.wb_cyc !== 3) begin n_bad++; $display("FAIL lw_wb_cycle got %0d want 3", o.wb_cyc); end
    run_op(32'h0000_0104, 32'h0, 3'b011, 1'b1, 1'b0, 5'd11, 1, 32'h8765_4321, 1'b0, o);
    n_cmp++; if (o.be !== 4'b1111) begin n_bad++; $display("FAIL f3_011_be got %b want 1111", o.be); end
    n_cmp++; if (o.wb_data !== 32'h8765_4321) begin n_bad++; $display("FAIL f3_011_data got %h want 87654321", o.wb_data); end
    run_op(32'h0000_0102, 32'h0, 3'b000, 1'b1, 1'b0, 5'd0, 1, 32'h0080_0000, 1'b0, o);
    n_cmp++; if (o.wb_we !== 1'b0) begin n_bad++; $display("FAIL lb_rd0_we got %b want 0", o.wb_we); end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(32'h0000_0102, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4, 1, 32'h0, 1'b0, o);
    n_cmp++; if (o.mis !== 1'b1) begin n_bad++; $display("FAIL lw_mis_flag got %b want 1", o.mis); end
    n_cmp++; if (o.wb_we !== 1'b0) begin n_bad++; $display("FAIL lw_mis_we got %b want 0", o.wb_we); end
    n_cmp++; if (o.req_cnt !== 0) begin n_bad++; $display("FAIL lw_mis_req got %0d want 0", o.req_cnt); end
    n_cmp++; if (o.wb_cyc !== 1) begin n_bad++; $display("FAIL lw_mis_cycle got %0d want 1", o.wb_cyc); end
    run_op(32'h0000_0101, 32'h5555, 3'b001, 1'b0, 1'b1, 5'd4, 1, 32'h0, 1'b0, o);
    n_cmp++; if (o.mis !== 1'b1) begin n_bad++; $display("FAIL sh_mis_flag got %b want 1", o.mis); end
    n_cmp++; if (o.req_cnt !== 0) begin n_bad++; $display("FAIL sh_mis_req got %0d want 0", o.req_cnt); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(32'h0000_0200, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 0, 32'h0, 1'b1, o);
    n_cmp++; if (o.req_cnt !== 4) begin n_bad++; $display("FAIL to_req_cycles got %0d want 4", o.req_cnt); end
    n_cmp++; if (o.wb_cyc !== 5) begin n_bad++; $display("FAIL to_wb_cycle got %0d want 5", o.wb_cyc); end
    n_cmp++; if (o.berr !== 1'b1) begin n_bad++; $display("FAIL to_bus_err got %b want 1", o.berr); end
    n_cmp++; if (o.wb_we !== 1'b0) begin n_bad++; $display("FAIL to_wb_we got %b want 0", o.wb_we); end
    n_cmp++; if (o.wbv_after !== 1'b0) begin n_bad++; $display("FAIL to_late_ack_wbv got %b want 0", o.wbv_after); end
    n_cmp++; if (o.req_after !== 1'b0) begin n_bad++; $display("FAIL to_late_ack_req got %b want 0", o.req_after); end
    n_cmp++; if (o.rdy_after !== 1'b1) begin n_bad++; $display("FAIL to_ready_after got %b want 1", o.rdy_after); end
  endtask

  task automatic test_reset_mid();
    ex_result = 32'h0000_0300; ex_funct3 = 3'b010; ex_is_load = 1'b1; ex_is_store = 1'b0;
    ex_rd = 5'd2; ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rm_req_before got %b want 1", dmem_req); end
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_async got %b want 0", dmem_req); end
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready_async got %b want 1", ex_ready); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (ex_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready_after got %b want 1", ex_ready); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rm_wbv_after got %b want 0", wb_valid); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_after got %b want 0", dmem_req); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, o3;
    run_op(32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0, 5'd12, 1, 32'h1111_2222, 1'b0, o1);
    run_op(32'h0000_0403, 32'h0, 3'b000, 1'b1, 1'b0, 5'd13, 1, 32'h9900_0000, 1'b0, o2);
    run_op(32'h0000_0400, 32'h0, 3'b101, 1'b1, 1'b0, 5'd14, 1, 32'h0000_F00F, 1'b0, o3);
    n_cmp++; if (o1.wb_data !== 32'h1111_2222) begin n_bad++; $display("FAIL b2b_0_data got %h want 11112222", o1.wb_data); end
    n_cmp++; if (o2.wb_data !== 32'hFFFF_FF99) begin n_bad++; $display("FAIL b2b_1_data got %h want ffffff99", o2.wb_data); end
    n_cmp++; if (o3.wb_data !== 32'h0000_F00F) begin n_bad++; $display("FAIL b2b_2_data got %h want 0000f00f", o3.wb_data); end
    n_cmp++; if (o2.rdy0 !== 1'b1) begin n_bad++; $display("FAIL b2b_1_ready got %b want 1", o2.rdy0); end
    n_cmp++; if (o2.wb_abs - o1.wb_abs !== 3) begin n_bad++; $display("FAIL b2b_gap01 got %0d want 3", o2.wb_abs - o1.wb_abs); end
    n_cmp++; if (o3.wb_abs - o2.wb_abs !== 3) begin n_bad++; $display("FAIL b2b_gap12 got %0d want 3", o3.wb_abs - o2.wb_abs); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store();
    test_loads();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
